gf_event_sequencer: RTL and testbench
=====================================

Name: gf_event_sequencer

Overview:
- Input-side controller for the GigaFitter fit datapath.
- Accepts strobed 23-bit SVT words, buffers them in an internal FIFO and counts complete events.
- Releases one event at a time to the fitter over a valid/ready stream, waits for fit completion, then forwards the end-event (EE) word downstream.
- Drives the upstream hold line so that the word source throttles before the buffer overflows.

Parameters:
- DEPTH, 64, FIFO depth in words, power of two.
- AW, 6, address width, log2(DEPTH).
- HOLD_MARGIN, 8, W_HOLD asserts when occupancy >= DEPTH-HOLD_MARGIN.

Ports:
- J3WRITECLK  in  1  single system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- DATA_IN  in  23  input word; EE word when DATA_IN[22:21]==2'b11, hit word otherwise (layer in [22:18]).
- DS_N  in  1  active-low data strobe, sampled synchronously; one word per cycle low.
- W_HOLD  out  1  upstream hold request.
- FIT_DATA  out  23  hit word to fitter.
- FIT_VALID  out  1  FIT_DATA valid.
- FIT_READY  in  1  fitter accepts word.
- FIT_EOE  out  1  one-cycle pulse: last hit of current event delivered.
- FIT_DONE  in  1  fitter finished current event (pulse or level).
- EE_OUT  out  23  EE word of the completed event.
- EE_VALID  out  1  one-cycle qualifier for EE_OUT.
- OVFL  out  1  sticky: a hit word was dropped.
- EVT_PENDING  out  AW+1  complete events held in the FIFO.

Behaviour:
- Reset: all outputs 0; FIFO empty; event counter 0; FSM in IDLE. Reset mid-event discards all buffered words and any partial fit without an EE.
- Write rules:
  - Write occurs on a rising edge with DS_N==0.
  - Hit word accepted only if occupancy < DEPTH-1; otherwise dropped and OVFL set. The last slot is reserved for an EE.
  - EE accepted if occupancy < DEPTH. If the FIFO is full, the EE is dropped and OVFL is set.
- FIFO is first-word-fall-through: a word written at edge k is at the head from k+1.
- Occupancy:
  - Simultaneous write and pop leave occupancy unchanged.
  - Pop on empty is impossible by construction.
- Event counter:
  - +1 on an accepted EE write, -1 on EE pop.
  - Both on the same edge leave it unchanged.
  - Drives EVT_PENDING.
- W_HOLD is registered and is 1 while occupancy >= DEPTH-HOLD_MARGIN, one cycle after the occupancy change.
- FSM:
  - IDLE: if EVT_PENDING>0, go to STREAM.
  - STREAM, head is a hit word: FIT_VALID=1 and FIT_DATA=head. Pop on FIT_READY. FIT_DATA holds while FIT_READY=0.
  - STREAM, head is an EE word: FIT_VALID=0. Latch head into the EE register, pop it, pulse FIT_EOE for one cycle, go to WAIT_DONE.
  - WAIT_DONE: on FIT_DONE=1 go to EMIT. FIT_DONE outside WAIT_DONE is ignored.
  - EMIT: EE_OUT=latched word, EE_VALID=1 for one cycle, then go to IDLE. EE_OUT holds its value until the next EMIT.
- Event with zero hits (EE only): FIT_EOE is still pulsed and FIT_DONE is still awaited.
- Latency, ready always high: EE written at edge k → counter=1 at k+1 → STREAM at k+2 → first FIT_VALID during cycle k+2. One hit per cycle after that.
- Writes continue during STREAM, WAIT_DONE and EMIT. Later events queue behind the current one.

Test Plan:
- Single event, FIT_READY=1: write 00cc0c, 0539da, 081a25, 0cc6c6, 1132d6, 15feed, 04b68c, 287e23, 600001 (one per cycle).
  - FIT_DATA presents the 8 hits in order, FIT_EOE pulses once after 287e23.
  - FIT_DONE 5 cycles later → EE_VALID with EE_OUT=600001.
  - EVT_PENDING returns to 0.
- Back-to-back events, FIT_DONE held off 20 cycles:
  - Write the event above, then 600002, then 9 hits + 600003.
  - EVT_PENDING reaches 3.
  - EE_OUT sequence is 600001, 600002 (zero hits: FIT_EOE pulses with no FIT_VALID), then 600003.
- Backpressure: toggle FIT_READY every cycle. FIT_DATA must be stable while FIT_READY=0, with no word lost or duplicated; compare against the 8-hit reference list.
- Overflow, FIT_READY=0:
  - Write 70 hits, then 600004.
  - W_HOLD rises after write 56 (occupancy 56).
  - 63 hits are stored and OVFL=1.
  - EE 600004 is stored, and the event is released with 63 hits followed by EE_OUT=600004.
- Reset mid-STREAM: assert RESET after 3 hits have been delivered.
  - All outputs are immediately 0 and EVT_PENDING=0.
  - After release, a fresh 600005 event is processed normally.
- Simultaneous write/pop: feed hits at 1/cycle while streaming with FIT_READY=1. Occupancy stays constant and W_HOLD never asserts.

Source files
------------

// File: rtl/gf_event_sequencer.sv
// Input-side event sequencer for the GigaFitter: buffers strobed SVT words in a
// FWFT FIFO, releases one event at a time to the fitter and forwards its EE word.
module gf_event_sequencer #(
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int HOLD_MARGIN = 8
) (
  input  logic          J3WRITECLK,
  input  logic          RESET,
  input  logic [22:0]   DATA_IN,
  input  logic          DS_N,
  output logic          W_HOLD,
  output logic [22:0]   FIT_DATA,
  output logic          FIT_VALID,
  input  logic          FIT_READY,
  output logic          FIT_EOE,
  input  logic          FIT_DONE,
  output logic [22:0]   EE_OUT,
  output logic          EE_VALID,
  output logic          OVFL,
  output logic [AW:0]   EVT_PENDING
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, EMIT} state_t;

  localparam logic [AW:0] OCC_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] OCC_HIT_MAX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] OCC_HOLD    = (AW+1)'(DEPTH - HOLD_MARGIN);

  state_t        state_q, state_d;
  logic [22:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d, evt_q, evt_d;
  logic          whold_q, whold_d, ovfl_q, ovfl_d;
  logic [22:0]   ee_lat_q, ee_lat_d, ee_out_q, ee_out_d;

  logic [22:0]   head;
  logic          head_ee, in_ee, wr_req, wr_ok, wr_en, pop;
  logic          fit_valid, fit_eoe;

  assign head    = mem_q[rd_ptr_q];
  assign head_ee = (head[22:21] == 2'b11);
  assign in_ee   = (DATA_IN[22:21] == 2'b11);
  assign wr_req  = ~DS_N;
  // Hits may not take the last slot, so an event's EE can always be stored.
  assign wr_ok   = in_ee ? (occ_q < OCC_FULL) : (occ_q < OCC_HIT_MAX);
  assign wr_en   = wr_req & wr_ok;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    fit_valid = 1'b0;
    fit_eoe   = 1'b0;
    ee_lat_d  = ee_lat_q;
    ee_out_d  = ee_out_q;
    case (state_q)
      IDLE: if (evt_q != '0) state_d = STREAM;
      STREAM: begin
        if (head_ee) begin
          pop      = 1'b1;
          fit_eoe  = 1'b1;
          ee_lat_d = head;
          state_d  = WAIT_DONE;
        end else begin
          fit_valid = 1'b1;
          pop       = FIT_READY;
        end
      end
      WAIT_DONE: if (FIT_DONE) begin
        ee_out_d = ee_lat_q;
        state_d  = EMIT;
      end
      EMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    evt_d    = evt_q + (AW+1)'(wr_en & in_ee) - (AW+1)'(pop & head_ee);
    ovfl_d   = ovfl_q | (wr_req & ~wr_ok);
    whold_d  = (occ_q >= OCC_HOLD);
  end

  always_ff @(posedge J3WRITECLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= DATA_IN;
  end

  always_ff @(posedge J3WRITECLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      evt_q    <= '0;
      whold_q  <= 1'b0;
      ovfl_q   <= 1'b0;
      ee_lat_q <= '0;
      ee_out_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      evt_q    <= evt_d;
      whold_q  <= whold_d;
      ovfl_q   <= ovfl_d;
      ee_lat_q <= ee_lat_d;
      ee_out_q <= ee_out_d;
    end
  end

  assign W_HOLD      = whold_q;
  assign FIT_VALID   = fit_valid;
  assign FIT_DATA    = fit_valid ? head : '0;
  assign FIT_EOE     = fit_eoe;
  assign EE_OUT      = ee_out_q;
  assign EE_VALID    = (state_q == EMIT);
  assign OVFL        = ovfl_q;
  assign EVT_PENDING = evt_q;

endmodule

// File: tb/tb_gf_event_sequencer.sv
// Directed bench for gf_event_sequencer: event release, zero-hit events,
// backpressure, overflow/hold, mid-stream reset and concurrent write/pop.
module tb_gf_event_sequencer;
  logic        clk = 1'b0;
  logic        rst, ds_n, fit_ready, fit_done;
  logic [22:0] data_in;
  logic        w_hold, fit_valid, fit_eoe, ee_valid, ovfl;
  logic [22:0] fit_data, ee_out;
  logic [6:0]  evt_pending;

  gf_event_sequencer #(.DEPTH(64), .AW(6), .HOLD_MARGIN(8)) dut (
    .J3WRITECLK(clk), .RESET(rst), .DATA_IN(data_in), .DS_N(ds_n),
    .W_HOLD(w_hold), .FIT_DATA(fit_data), .FIT_VALID(fit_valid),
    .FIT_READY(fit_ready), .FIT_EOE(fit_eoe), .FIT_DONE(fit_done),
    .EE_OUT(ee_out), .EE_VALID(ee_valid), .OVFL(ovfl),
    .EVT_PENDING(evt_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [22:0] fit_q [$];
  logic [22:0] ee_q [$];
  int          eoe_cnt = 0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [22:0] prev_data = '0;
  logic [22:0] ref8 [8] = '{23'h00cc0c, 23'h0539da, 23'h081a25, 23'h0cc6c6,
                            23'h1132d6, 23'h15feed, 23'h04b68c, 23'h287e23};

  // Capture handshakes away from the active edge.
  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!fit_valid || fit_data !== prev_data)) stab_err++;
      prev_stall = fit_valid && !fit_ready;
      prev_data  = fit_data;
      if (fit_valid && fit_ready) fit_q.push_back(fit_data);
      if (fit_eoe) eoe_cnt++;
      if (ee_valid) ee_q.push_back(ee_out);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [22:0] w);
    ds_n = 1'b0; data_in = w; step(1); ds_n = 1'b1;
  endtask

  task automatic wait_eoe(input int n, input string tag);
    int t = 0;
    while (eoe_cnt < n && t < 1000) begin step(1); t++; end
    chk(tag, 32'(eoe_cnt >= n), 32'd1);
  endtask

  task automatic wait_ee(input int n, input string tag);
    int t = 0;
    while (ee_q.size() < n && t < 1000) begin step(1); t++; end
    chk(tag, 32'(ee_q.size() >= n), 32'd1);
  endtask

  task automatic done_pulse(input int dly);
    step(dly); fit_done = 1'b1; step(1); fit_done = 1'b0;
  endtask

  task automatic clr();
    fit_q.delete(); ee_q.delete(); eoe_cnt = 0; stab_err = 0;
  endtask

  task automatic chk_ref8(input string tag, input int base);
    for (int i = 0; i < 8; i++)
      if (fit_q.size() > base + i)
        chk($sformatf("%s_%0d", tag, i), 32'(fit_q[base+i]), 32'(ref8[i]));
  endtask

  initial begin
    logic [22:0] w6 [16];
    logic        hold_seen;
    int          t;
    rst = 1'b1; ds_n = 1'b1; data_in = '0; fit_ready = 1'b0; fit_done = 1'b0;
    step(3);
    chk("rst_fit_valid", 32'(fit_valid), 32'd0);
    chk("rst_ee_valid", 32'(ee_valid), 32'd0);
    chk("rst_whold", 32'(w_hold), 32'd0);
    chk("rst_ovfl", 32'(ovfl), 32'd0);
    chk("rst_evt", 32'(evt_pending), 32'd0);
    chk("rst_ee_out", 32'(ee_out), 32'd0);
    rst = 1'b0;
    step(1);

    // single event, ready high
    fit_ready = 1'b1;
    for (int i = 0; i < 8; i++) wr(ref8[i]);
    wr(23'h600001);
    chk("t1_evt1", 32'(evt_pending), 32'd1);
    chk("t1_not_yet", 32'(fit_valid), 32'd0);
    step(1);
    chk("t1_first_valid", 32'(fit_valid), 32'd1);
    chk("t1_first_data", 32'(fit_data), 32'h00cc0c);
    wait_eoe(1, "t1_eoe_to");
    chk("t1_evt0", 32'(evt_pending), 32'd0);
    chk("t1_nhits", 32'(fit_q.size()), 32'd8);
    chk_ref8("t1_hit", 0);
    done_pulse(5);
    wait_ee(1, "t1_ee_to");
    chk("t1_ee", 32'(ee_q[0]), 32'h600001);
    chk("t1_ee_pulse", 32'(ee_valid), 32'd0);
    chk("t1_ee_hold", 32'(ee_out), 32'h600001);
    chk("t1_eoe_once", 32'(eoe_cnt), 32'd1);

    // back-to-back events, one with zero hits
    clr(); fit_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(ref8[i]);
    wr(23'h600001);
    wr(23'h600002);
    for (int i = 0; i < 9; i++) wr(23'h010001 + 23'(i));
    wr(23'h600003);
    chk("t2_evt3", 32'(evt_pending), 32'd3);
    fit_done = 1'b1; step(1); fit_done = 1'b0;
    fit_ready = 1'b1;
    wait_eoe(1, "t2_eoe1_to");
    chk("t2_n1", 32'(fit_q.size()), 32'd8);
    done_pulse(20);
    wait_eoe(2, "t2_eoe2_to");
    chk("t2_zero_hit", 32'(fit_q.size()), 32'd8);
    done_pulse(20);
    wait_eoe(3, "t2_eoe3_to");
    chk("t2_n3", 32'(fit_q.size()), 32'd17);
    done_pulse(20);
    wait_ee(3, "t2_ee_to");
    chk_ref8("t2_hit", 0);
    for (int i = 0; i < 9; i++)
      if (fit_q.size() > 8 + i)
        chk($sformatf("t2_hitb_%0d", i), 32'(fit_q[8+i]), 32'h010001 + i);
    if (ee_q.size() >= 3) begin
      chk("t2_ee0", 32'(ee_q[0]), 32'h600001);
      chk("t2_ee1", 32'(ee_q[1]), 32'h600002);
      chk("t2_ee2", 32'(ee_q[2]), 32'h600003);
    end
    chk("t2_evt0", 32'(evt_pending), 32'd0);

    // backpressure: ready toggles every cycle
    clr(); fit_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(ref8[i]);
    wr(23'h600001);
    t = 0;
    while (eoe_cnt < 1 && t < 200) begin fit_ready = ~fit_ready; step(1); t++; end
    chk("t3_eoe", 32'(eoe_cnt), 32'd1);
    chk("t3_stable", 32'(stab_err), 32'd0);
    chk("t3_nhits", 32'(fit_q.size()), 32'd8);
    chk_ref8("t3_hit", 0);
    done_pulse(2);
    wait_ee(1, "t3_ee_to");

    // overflow with fitter stalled
    clr(); fit_ready = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      wr(23'h020000 + 23'(i));
      if (i == 56) chk("t4_hold_56", 32'(w_hold), 32'd0);
      if (i == 57) chk("t4_hold_57", 32'(w_hold), 32'd1);
      if (i == 63) chk("t4_ovfl_63", 32'(ovfl), 32'd0);
      if (i == 64) chk("t4_ovfl_64", 32'(ovfl), 32'd1);
    end
    wr(23'h600004);
    chk("t4_ee_stored", 32'(evt_pending), 32'd1);
    step(2);
    fit_done = 1'b1; step(1); fit_done = 1'b0;
    chk("t4_hold_full", 32'(w_hold), 32'd1);
    fit_ready = 1'b1;
    wait_eoe(1, "t4_eoe_to");
    chk("t4_nhits", 32'(fit_q.size()), 32'd63);
    for (int i = 0; i < 63; i++)
      if (fit_q.size() > i)
        chk($sformatf("t4_hit_%0d", i), 32'(fit_q[i]), 32'h020001 + i);
    step(1);
    chk("t4_hold_drop", 32'(w_hold), 32'd0);
    done_pulse(3);
    wait_ee(1, "t4_ee_to");
    chk("t4_ee", 32'(ee_q[0]), 32'h600004);
    chk("t4_ovfl_sticky", 32'(ovfl), 32'd1);

    // reset in the middle of streaming
    clr(); fit_ready = 1'b1;
    for (int i = 0; i < 8; i++) wr(ref8[i]);
    wr(23'h600001);
    t = 0;
    while (fit_q.size() < 3 && t < 100) begin step(1); t++; end
    chk("t5_three", 32'(fit_q.size()), 32'd3);
    rst = 1'b1; #1;
    chk("t5_fit_valid", 32'(fit_valid), 32'd0);
    chk("t5_fit_data", 32'(fit_data), 32'd0);
    chk("t5_evt", 32'(evt_pending), 32'd0);
    chk("t5_ovfl", 32'(ovfl), 32'd0);
    chk("t5_ee_out", 32'(ee_out), 32'd0);
    chk("t5_eoe", 32'(fit_eoe), 32'd0);
    step(2); rst = 1'b0; clr(); step(1);
    wr(23'h030001); wr(23'h030002); wr(23'h600005);
    wait_eoe(1, "t5_eoe_to");
    done_pulse(1);
    wait_ee(1, "t5_ee_to");
    chk("t5_nhits", 32'(fit_q.size()), 32'd2);
    if (fit_q.size() >= 2) begin
      chk("t5_hit0", 32'(fit_q[0]), 32'h030001);
      chk("t5_hit1", 32'(fit_q[1]), 32'h030002);
    end
    chk("t5_ee", 32'(ee_q[0]), 32'h600005);

    // writes overlap with streaming pops
    clr(); fit_ready = 1'b1; hold_seen = 1'b0;
    for (int i = 0; i < 4; i++) w6[i] = 23'h040001 + 23'(i);
    w6[4] = 23'h600006;
    for (int i = 0; i < 10; i++) w6[5+i] = 23'h040011 + 23'(i);
    w6[15] = 23'h600007;
    for (int i = 0; i < 16; i++) begin wr(w6[i]); hold_seen |= w_hold; end
    wait_eoe(1, "t6_eoe1_to");
    done_pulse(1);
    wait_eoe(2, "t6_eoe2_to");
    done_pulse(1);
    wait_ee(2, "t6_ee_to");
    chk("t6_no_hold", 32'(hold_seen), 32'd0);
    chk("t6_nhits", 32'(fit_q.size()), 32'd14);
    for (int i = 0; i < 14; i++)
      if (fit_q.size() > i)
        chk($sformatf("t6_hit_%0d", i), 32'(fit_q[i]),
            32'(i < 4 ? w6[i] : w6[i+1]));
    if (ee_q.size() >= 2) begin
      chk("t6_ee0", 32'(ee_q[0]), 32'h600006);
      chk("t6_ee1", 32'(ee_q[1]), 32'h600007);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
